// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready handshake on both sides.
//
// An operation is accepted in IDLE when in_valid and in_ready are both high.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) are evaluated at accept
// and registered, so the block is in DONE on the next cycle. MUL is an
// unsigned shift-add multiplier that spends exactly WIDTH cycles in the MUL
// state before it moves to DONE. DONE holds result and flags until the
// consumer takes them with out_ready. A new operation is accepted no earlier
// than the cycle after that.
//
// Configuration macro: SEQ_ALU_MUL_EN
//   defined   : opcode 111 runs the shift-add multiplier (MUL state present).
//   undefined : there is no MUL state. Opcode 111 completes in one cycle with
//               result=0, zero=1, overflow=0, carry=0, err=1.
//
// Parameters
//   WIDTH      operand/result width in bits (4..32), default 8
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands/opcode presented
//   in_ready   out  1      high only in IDLE
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B; also the shift amount
//   op         in   3      opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                          101 SHL, 110 SHR, 111 MUL
//   out_valid  out  1      result and flags valid (DONE state)
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   overflow   out  1      signed overflow (ADD/SUB) or truncation (MUL)
//   carry      out  1      ADD carry-out / SUB borrow
//   err        out  1      opcode not supported in this build
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             err
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // Shift amounts at or above this value push every bit out of the word.
   localparam logic [WIDTH-1:0] LP_WIDTH_V = WIDTH'(WIDTH);

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd2
   } state_t;
`endif

   state_t r_state;
   state_t w_state_next;

   // Asserted when a single-cycle result from the combinational ALU is loaded.
   logic w_load_alu;

   // Result/flag registers.
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_overflow;
   logic             r_carry;
   logic             r_err;

   // ---------------------------------------------------------------------
   // Single-cycle ALU, evaluated on the live inputs. It is used only in the
   // accept cycle, so the operands are effectively captured at accept.
   // ---------------------------------------------------------------------
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_shift_oob;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_alu_overflow;
   logic             w_alu_carry;
   logic             w_alu_err;

   assign w_sum       = {1'b0, a} + {1'b0, b};
   // Bit WIDTH of the extended difference is the unsigned borrow (a < b).
   assign w_diff      = {1'b0, a} - {1'b0, b};
   assign w_shift_oob = (b >= LP_WIDTH_V);

   always_comb begin
      w_alu_result   = '0;
      w_alu_overflow = 1'b0;
      w_alu_carry    = 1'b0;
      w_alu_err      = 1'b0;
      case (op)
         OP_ADD: begin
            w_alu_result   = w_sum[WIDTH-1:0];
            w_alu_carry    = w_sum[WIDTH];
            // Same-sign operands with a result of the other sign.
            w_alu_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_result   = w_diff[WIDTH-1:0];
            w_alu_carry    = w_diff[WIDTH];
            // Operands of different sign with a result whose sign differs
            // from a.
            w_alu_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: w_alu_result = a & b;
         OP_OR:  w_alu_result = a | b;
         OP_XOR: w_alu_result = a ^ b;
         OP_SHL: w_alu_result = w_shift_oob ? '0 : (a << b);
         OP_SHR: w_alu_result = w_shift_oob ? '0 : (a >> b);
         OP_MUL: begin
`ifndef SEQ_ALU_MUL_EN
            // Without the multiplier, MUL completes at once as an error.
            w_alu_err = 1'b1;
`endif
         end
         default: begin
            w_alu_result = '0;
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   // ---------------------------------------------------------------------
   // Shift-add multiplier. The multiplicand shifts left and the multiplier
   // shifts right once per cycle; the accumulator adds the multiplicand
   // whenever the current multiplier LSB is set. After WIDTH steps the
   // accumulator holds the full 2*WIDTH product.
   // ---------------------------------------------------------------------
   localparam int              CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_mul_start;
   logic               w_mul_done;

   assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_start = (r_state == S_IDLE) && in_valid && (op == OP_MUL);
   assign w_mul_done  = (r_state == S_MUL) && (r_cnt == LP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_mul_start) begin
         r_mcand  <= {{WIDTH{1'b0}}, a};
         r_mplier <= b;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_acc    <= w_acc_next;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // FSM: state register.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and handshake outputs.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      w_load_alu   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
               if (op == OP_MUL) begin
                  w_state_next = S_MUL;
               end else begin
                  w_state_next = S_DONE;
                  w_load_alu   = 1'b1;
               end
`else
               w_state_next = S_DONE;
               w_load_alu   = 1'b1;
`endif
            end
         end
`ifdef SEQ_ALU_MUL_EN
         S_MUL: begin
            if (r_cnt == LP_LAST) begin
               w_state_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            out_valid = 1'b1;
            // Return to IDLE only; the next accept happens a cycle later.
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Result and flag registers. They load only on a completing operation, so
   // they hold steady throughout DONE regardless of out_ready.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_carry    <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_load_alu) begin
         r_result   <= w_alu_result;
         r_zero     <= (w_alu_result == '0);
         r_overflow <= w_alu_overflow;
         r_carry    <= w_alu_carry;
         r_err      <= w_alu_err;
      end
`ifdef SEQ_ALU_MUL_EN
      else if (w_mul_done) begin
         // Take the final step's sum directly so that DONE is entered on the
         // same edge as the last shift-add.
         r_result   <= w_acc_next[WIDTH-1:0];
         r_zero     <= (w_acc_next[WIDTH-1:0] == '0);
         r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
         r_carry    <= 1'b0;
         r_err      <= 1'b0;
      end
`endif
   end

   assign result   = r_result;
   assign zero     = r_zero;
   assign overflow = r_overflow;
   assign carry    = r_carry;
   assign err      = r_err;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operand/op presented.
REQ-006 Port: in_ready  output  1  block accepts a new operation.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B; also the shift amount.
REQ-009 Port: op  input  3  opcode.
REQ-010 Port: out_valid  output  1  result and flags valid.
REQ-011 Port: out_ready  input  1  consumer takes the result.
REQ-012 Port: result  output  WIDTH  registered result.
REQ-013 Port: zero  output  1  result == 0.
REQ-014 Port: overflow  output  1  signed overflow (ADD/SUB) or truncation (MUL).
REQ-015 Port: carry  output  1  ADD carry-out / SUB borrow.
REQ-016 Port: err  output  1  opcode not supported in this build.

Function
REQ-017 Opcodes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL logical, 110 SHR logical, 111 MUL (unsigned, low WIDTH bits).
REQ-018 FSM states SHALL be IDLE, MUL, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; accept occurs on the edge where in_valid and in_ready are both 1.
REQ-020 A non-MUL op accepted in IDLE SHALL move to DONE, with out_valid=1 on the next cycle (latency 1).
REQ-021 A MUL op SHALL enter MUL and run a shift-add over exactly WIDTH cycles, then enter DONE (out_valid WIDTH+1 cycles after accept).
REQ-022 In DONE, result/flags SHALL hold stable while out_ready=0; DONE->IDLE on out_valid&&out_ready. No new accept is allowed in the same cycle.
REQ-023 Operands SHALL be captured at accept; later changes to a/b/op SHALL NOT affect the result.
REQ-024 ADD: carry = bit WIDTH of a+b; overflow = signed overflow.
REQ-025 SUB: carry = 1 when a < b (unsigned); overflow = signed overflow.
REQ-026 Logic ops and shifts SHALL set carry=0 and overflow=0.
REQ-027 Shifts SHALL use the full value of b; b >= WIDTH SHALL yield result 0.
REQ-028 MUL: overflow = 1 when any bit of the upper WIDTH of the 2*WIDTH product is nonzero; carry = 0.
REQ-029 zero SHALL equal (result == 0) for every op, including on an err result.
REQ-030 err SHALL be 0 for all supported ops.

Reset
REQ-031 On rst=1 at a clock edge the FSM SHALL go to IDLE, and out_valid, result, zero, overflow, carry and err SHALL all be 0. The following cycle in_ready SHALL be 1.
REQ-032 Reset during MUL or DONE SHALL abort the operation; no out_valid is produced for it.

Configuration
REQ-033 Macro SEQ_ALU_MUL_EN: when defined, MUL is implemented per REQ-021/REQ-028.
REQ-034 Without SEQ_ALU_MUL_EN, the MUL state is absent and op 111 completes with latency 1: result=0, zero=1, overflow=0, carry=0, err=1.

Verification (WIDTH=8)
REQ-035 ADD a=127, b=1 -> result=128, overflow=1, carry=0, zero=0; out_valid 1 cycle after accept.
REQ-036 SUB a=5, b=5 -> result=0, zero=1, carry=0. SUB a=3, b=5 -> result=254, carry=1, overflow=0.
REQ-037 MUL a=16, b=16 (macro on) -> result=0, zero=1, overflow=1, out_valid 9 cycles after accept, in_ready=0 throughout. Macro off -> err=1 after 1 cycle.
REQ-038 SHL a=1, b=7 -> result=128. SHL a=1, b=8 -> result=0, zero=1. SHR a=128, b=200 -> result=0.
REQ-039 ADD 10+20 with out_ready=0 for 5 cycles -> result=30 held, out_valid=1, in_ready=0. out_ready=1 -> IDLE next cycle.
REQ-040 rst asserted on the 3rd MUL cycle -> next cycle in_ready=1 and out_valid=0; no result is emitted for that operation.
